cpc_bus_master: RTL
===================

Name: cpc_bus_master

Overview:
- Initiator for the CPC expansion-bus protocol that the RAM expansion CPLD responds to.
- Accepts one command at a time: memory read, memory write, I/O write or I/O read.
- Generates Z80-style T-state bus cycles, honours the ready wait line and returns a read-data/status response.
- Keeps a shadow copy of the last bank-select byte written to 0x7Fxx. Used as the host-side driver in test rigs and FPGA CPC cores.

Parameters:
- IO_WAIT, 1: mandatory wait states inserted in every I/O cycle (0-3).
- TIMEOUT, 64: maximum consecutive wait states before abort (1-255).

Ports:
- clk  input  1  system clock; one T-state per cycle
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block can accept a command
- cmd_type  input  2  00 mem read, 01 mem write, 10 io write, 11 io read
- cmd_adr  input  16  bus address
- cmd_data  input  8  write data
- rsp_valid  output  1  one-cycle response pulse
- rsp_data  output  8  read data; 0x00 for writes and for aborted cycles
- rsp_err  output  1  cycle aborted by timeout; qualified by rsp_valid
- adr  output  16  bus address
- data_out  output  8  bus write data
- data_oe  output  1  drive data_out onto the bus
- data_in  input  8  bus read data
- mreq_b  output  1  memory request, active low
- iorq_b  output  1  I/O request, active low
- rd_b  output  1  read strobe, active low
- wr_b  output  1  write strobe, active low
- ramrd_b  output  1  low during memory reads only
- ready  input  1  low requests a wait state
- bank_q  output  6  shadow of the last accepted bank select (cccbbb)

Behaviour:
- Reset, synchronous and active-high, dominates all other inputs. Values under reset:
  - all strobes (mreq_b, iorq_b, rd_b, wr_b, ramrd_b) = 1
  - data_oe = 0; adr = 0; data_out = 0
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0
  - bank_q = 0
  - state IDLE; cmd_ready = 1 on the first cycle after reset deasserts
- Reset asserted mid-cycle: strobes return high at the next edge, no response is issued, and bank_q is cleared.
- States are IDLE, T1, T2, TWA, TW, T3.
- cmd_ready is 1 only in IDLE. A handshake is cmd_valid & cmd_ready at an edge; the command is captured and the state moves to T1.
- T1: adr = captured address. data_out = cmd_data and data_oe = 1 for writes. All strobes stay high.
- T2:
  - memory cycles: mreq_b = 0.
  - I/O cycles: iorq_b = 0.
  - reads: rd_b = 0; memory reads also drive ramrd_b = 0.
  - writes: wr_b = 0.
  - Next state: TWA if the cycle is I/O and IO_WAIT > 0; otherwise TW if ready = 0, else T3.
- TWA: strobes held. Counts IO_WAIT cycles; after the last one, goes to TW if ready = 0, else T3.
- TW: strobes held. The wait counter increments each cycle.
  - ready = 1 at an edge: go to T3.
  - counter reaches TIMEOUT with ready still low: go to T3 with the abort flag set.
- T3: strobes held for this cycle. At the T3 -> IDLE edge:
  - rsp_valid = 1 for one cycle.
  - rsp_data = data_in sampled at that edge for reads (0x00 if aborted).
  - rsp_err = abort flag.
  - strobes go high and data_oe = 0.
  - adr holds its value until the next T1.
- Cycle length: memory 3 + waits; I/O 3 + IO_WAIT + waits. ready is ignored in T1 and T3.
- Bank shadow: bank_q <= cmd_data[5:0] at the T3 edge only when all of these hold:
  - I/O write cycle
  - adr[15] = 0
  - cmd_data[7:6] = 11
  - not aborted
  Any other I/O write leaves bank_q unchanged.
- The wait counter is 8 bits and is cleared in T1. No wrap: the abort fires at exactly TIMEOUT.
- A command may be accepted on the cycle immediately after rsp_valid (back-to-back), with no idle gap beyond the IDLE cycle.
- cmd_valid while busy is ignored and not queued.

Test Plan:
- Reset then mem write 0x4000 <- 0xA5, ready = 1: mreq_b/wr_b low for exactly 2 cycles (T2, T3); data_oe high for 3 cycles; rsp_valid one pulse, rsp_err = 0, rsp_data = 0x00.
- Mem read 0xC000, ready low 3 cycles in TW, data_in = 0x5A: cycle length 6; rd_b and ramrd_b low together; rsp_data = 0x5A.
- I/O write 0x7F00 <- 0xC9 with IO_WAIT = 1: iorq_b low 3 cycles, mreq_b high throughout, bank_q = 0x09. Then I/O write 0x7F00 <- 0x89: bank_q stays 0x09.
- I/O write 0xBC00 <- 0xC3: bank_q unchanged (adr[15] = 1).
- Mem read with ready held low, TIMEOUT = 4: abort after 4 TW cycles; rsp_err = 1, rsp_data = 0x00, strobes high after T3; next command accepted normally.
- Reset asserted during TW of an I/O write: strobes high on the next edge, no rsp_valid, bank_q = 0, cmd_ready = 1 after release.

Source files
------------

// File: rtl/cpc_bus_master.sv
// CPC expansion-bus initiator: runs one Z80-style T-state bus cycle per command,
// honours the ready wait line with a timeout, and shadows the last 0x7Fxx bank-select byte.
module cpc_bus_master #(
    parameter int IO_WAIT = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [15:0] cmd_adr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [15:0] adr,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in,
    output logic        mreq_b,
    output logic        iorq_b,
    output logic        rd_b,
    output logic        wr_b,
    output logic        ramrd_b,
    input  logic        ready,
    output logic [5:0]  bank_q
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TWA  = 3'd3,
        S_TW   = 3'd4,
        S_T3   = 3'd5
    } state_t;

    localparam logic [1:0] TWA_LAST = 2'((IO_WAIT > 0) ? (IO_WAIT - 1) : 0);
    localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [15:0] adr_q, adr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  twa_cnt_q, twa_cnt_d;
    logic        abort_q, abort_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [5:0]  bank_sh_q, bank_sh_d;
    logic        mreq_b_q, mreq_b_d;
    logic        iorq_b_q, iorq_b_d;
    logic        rd_b_q, rd_b_d;
    logic        wr_b_q, wr_b_d;
    logic        ramrd_b_q, ramrd_b_d;
    logic        data_oe_q, data_oe_d;

    logic        is_read_q, is_read_d;
    logic        strobe_act;
    logic [7:0]  wait_cnt_inc;

    // Read commands are 00 (mem) and 11 (io): both type bits equal.
    assign is_read_q    = (type_q[1] == type_q[0]);
    assign is_read_d    = (type_d[1] == type_d[0]);
    assign wait_cnt_inc = wait_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        adr_d       = adr_q;
        dout_d      = dout_q;
        wait_cnt_d  = wait_cnt_q;
        twa_cnt_d   = twa_cnt_q;
        abort_d     = abort_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 8'h00;
        rsp_err_d   = 1'b0;
        bank_sh_d   = bank_sh_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_T1;
                    type_d  = cmd_type;
                    adr_d   = cmd_adr;
                    if (cmd_type[1] != cmd_type[0]) begin
                        dout_d = cmd_data;
                    end
                end
            end
            S_T1: begin
                wait_cnt_d = 8'd0;
                twa_cnt_d  = 2'd0;
                abort_d    = 1'b0;
                state_d    = S_T2;
            end
            S_T2: begin
                if (type_q[1] && (IO_WAIT > 0)) begin
                    state_d = S_TWA;
                end else if (!ready) begin
                    state_d = S_TW;
                end else begin
                    state_d = S_T3;
                end
            end
            S_TWA: begin
                if (twa_cnt_q == TWA_LAST) begin
                    state_d = ready ? S_T3 : S_TW;
                end else begin
                    twa_cnt_d = twa_cnt_q + 2'd1;
                end
            end
            S_TW: begin
                wait_cnt_d = wait_cnt_inc;
                if (ready) begin
                    state_d = S_T3;
                end else if (wait_cnt_inc == TO_CNT) begin
                    abort_d = 1'b1;
                    state_d = S_T3;
                end
            end
            S_T3: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = abort_q;
                if (is_read_q && !abort_q) begin
                    rsp_data_d = data_in;
                end
                // Gate-array bank select: I/O write to A15=0 with data 11cccbbb.
                if ((type_q == 2'b10) && !adr_q[15] && (dout_q[7:6] == 2'b11) && !abort_q) begin
                    bank_sh_d = dout_q[5:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so the bus sees clean edges.
        strobe_act = (state_d == S_T2) || (state_d == S_TWA) ||
                     (state_d == S_TW) || (state_d == S_T3);
        mreq_b_d   = !(strobe_act && !type_d[1]);
        iorq_b_d   = !(strobe_act && type_d[1]);
        rd_b_d     = !(strobe_act && is_read_d);
        wr_b_d     = !(strobe_act && !is_read_d);
        ramrd_b_d  = !(strobe_act && (type_d == 2'b00));
        data_oe_d  = (state_d != S_IDLE) && !is_read_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            type_q      <= 2'b00;
            adr_q       <= 16'h0000;
            dout_q      <= 8'h00;
            wait_cnt_q  <= 8'd0;
            twa_cnt_q   <= 2'd0;
            abort_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            bank_sh_q   <= 6'd0;
            mreq_b_q    <= 1'b1;
            iorq_b_q    <= 1'b1;
            rd_b_q      <= 1'b1;
            wr_b_q      <= 1'b1;
            ramrd_b_q   <= 1'b1;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            adr_q       <= adr_d;
            dout_q      <= dout_d;
            wait_cnt_q  <= wait_cnt_d;
            twa_cnt_q   <= twa_cnt_d;
            abort_q     <= abort_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            bank_sh_q   <= bank_sh_d;
            mreq_b_q    <= mreq_b_d;
            iorq_b_q    <= iorq_b_d;
            rd_b_q      <= rd_b_d;
            wr_b_q      <= wr_b_d;
            ramrd_b_q   <= ramrd_b_d;
            data_oe_q   <= data_oe_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign adr       = adr_q;
    assign data_out  = dout_q;
    assign data_oe   = data_oe_q;
    assign mreq_b    = mreq_b_q;
    assign iorq_b    = iorq_b_q;
    assign rd_b      = rd_b_q;
    assign wr_b      = wr_b_q;
    assign ramrd_b   = ramrd_b_q;
    assign bank_q    = bank_sh_q;

endmodule
